// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the processor datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, waits on the
// memory-ready handshake, and drives the datapath control nets plus
// halt/illegal status and a retired-instruction counter.
module multicycle_control_unit (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    input  logic        i_sinal_zero,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_ir_write,
    output logic        o_mem_read,
    output logic        o_controle_memdados,
    output logic        o_controle_bancoreg,
    output logic        o_controle_mux1,
    output logic        o_controle_mux2,
    output logic        o_controle_mux3,
    output logic [1:0]  o_controle_mux4,
    output logic [2:0]  o_controle_alu,
    output logic [2:0]  o_state,
    output logic        o_halted,
    output logic        o_illegal,
    output logic [15:0] o_instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t      r_state;
    logic [5:0]  r_opcode;
    logic [5:0]  r_funct;
    logic        r_halted;
    logic        r_illegal;
    logic [15:0] r_instr_count;
    logic        w_decode_legal;

    // ALU operation for an R-type function code; only legal codes reach EXEC/WB.
    function automatic logic [2:0] alu_for_funct(input logic [5:0] f);
        case (f)
            6'b100000: return ALU_ADD;
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_AND;
        endcase
    endfunction

    function automatic logic funct_legal(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    // Decode legality uses the live inputs because the latch happens on the same edge.
    assign w_decode_legal = (i_opcode == OP_RTYPE) ? funct_legal(i_funct)
                          : (i_opcode inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J});

    // Sequencer: state, latched instruction fields, sticky flags and retire counter.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_FETCH;
            r_opcode      <= '0;
            r_funct       <= '0;
            r_halted      <= 1'b0;
            r_illegal     <= 1'b0;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_opcode <= i_opcode;
                    r_funct  <= i_funct;
                    if (i_opcode == OP_HALT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (!w_decode_legal) begin
                        r_state   <= S_HALT;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_opcode)
                        OP_LW, OP_SW: r_state <= S_MEM;
                        OP_BEQ, OP_J: begin
                            r_state       <= S_FETCH;
                            r_instr_count <= r_instr_count + 16'd1;
                        end
                        default: r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (i_mem_ready) begin
                        if (r_opcode == OP_LW) begin
                            r_state <= S_WB;
                        end else begin
                            r_state       <= S_FETCH;
                            r_instr_count <= r_instr_count + 16'd1;
                        end
                    end
                end
                S_WB: begin
                    r_state       <= S_FETCH;
                    r_instr_count <= r_instr_count + 16'd1;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Control decode from state and latched opcode; FETCH/MEM strobes gated by memory ready.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_pc_write          = 1'b0;
        o_ir_write          = 1'b0;
        o_mem_read          = 1'b0;
        o_controle_memdados = 1'b0;
        o_controle_bancoreg = 1'b0;
        o_controle_mux1     = 1'b0;
        o_controle_mux2     = 1'b0;
        o_controle_mux3     = 1'b0;
        o_controle_mux4     = 2'b00;
        o_controle_alu      = ALU_AND;
        case (r_state)
            S_FETCH: begin
                o_mem_read = 1'b1;
                o_pc_write = i_mem_ready;
                o_ir_write = i_mem_ready;
            end
            S_EXEC: begin
                case (r_opcode)
                    OP_RTYPE: o_controle_alu = alu_for_funct(r_funct);
                    OP_ADDI, OP_LW, OP_SW: begin
                        o_controle_mux2 = 1'b1;
                        o_controle_alu  = ALU_ADD;
                    end
                    OP_BEQ: begin
                        o_controle_alu  = ALU_SUB;
                        o_controle_mux4 = 2'b01;
                        o_pc_write      = i_sinal_zero;
                    end
                    OP_J: begin
                        o_controle_mux4 = 2'b10;
                        o_pc_write      = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                o_controle_mux2 = 1'b1;
                o_controle_alu  = ALU_ADD;
                if (r_opcode == OP_LW) o_mem_read = 1'b1;
                else                   o_controle_memdados = i_mem_ready;
            end
            S_WB: begin
                o_controle_bancoreg = 1'b1;
                case (r_opcode)
                    OP_RTYPE: begin
                        o_controle_mux1 = 1'b1;
                        o_controle_alu  = alu_for_funct(r_funct);
                    end
                    OP_ADDI: begin
                        o_controle_mux2 = 1'b1;
                        o_controle_alu  = ALU_ADD;
                    end
                    OP_LW:   o_controle_mux3 = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (i_reset) begin
            o_pc_write          = 1'b0;
            o_ir_write          = 1'b0;
            o_mem_read          = 1'b0;
            o_controle_memdados = 1'b0;
            o_controle_bancoreg = 1'b0;
        end
    end

    assign o_state       = r_state;
    assign o_halted      = r_halted;
    assign o_illegal     = r_illegal;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. A behavioural model
// expands each instruction into its expected per-cycle control trace,
// which is driven and compared cycle by cycle.
module tb_multicycle_control_unit;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic        rdy;
    logic        pc_write, ir_write, mem_read, memdados, bancoreg;
    logic        mux1, mux2, mux3;
    logic [1:0]  mux4;
    logic [2:0]  alu;
    logic [2:0]  state;
    logic        halted, illegal;
    logic [15:0] instr_count;
    logic [33:0] obs;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [15:0] m_count;
    logic        m_halted;
    logic        m_illegal;

    typedef struct {
        logic        rdy;
        logic        zero;
        logic        real_op;
        logic [33:0] exp;
    } cyc_t;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .i_clock             (clk),
        .i_reset             (rst),
        .i_opcode            (op),
        .i_funct             (fn),
        .i_sinal_zero        (zero),
        .i_mem_ready         (rdy),
        .o_pc_write          (pc_write),
        .o_ir_write          (ir_write),
        .o_mem_read          (mem_read),
        .o_controle_memdados (memdados),
        .o_controle_bancoreg (bancoreg),
        .o_controle_mux1     (mux1),
        .o_controle_mux2     (mux2),
        .o_controle_mux3     (mux3),
        .o_controle_mux4     (mux4),
        .o_controle_alu      (alu),
        .o_state             (state),
        .o_halted            (halted),
        .o_illegal           (illegal),
        .o_instr_count       (instr_count)
    );

    assign obs = {state, pc_write, ir_write, mem_read, memdados, bancoreg,
                  mux1, mux2, mux3, mux4, alu, halted, illegal, instr_count};

    // strobes = {pc_write, ir_write, mem_read, memdados, bancoreg}; muxes = {mux1, mux2, mux3}
    function automatic logic [33:0] vec(input logic [2:0] st, input logic [4:0] strobes,
                                        input logic [2:0] muxes, input logic [1:0] m4,
                                        input logic [2:0] a);
        return {st, strobes, muxes, m4, a, m_halted, m_illegal, m_count};
    endfunction

    function automatic cyc_t mk(input logic r, input logic z, input logic real_op, input logic [33:0] e);
        cyc_t c;
        c.rdy = r; c.zero = z; c.real_op = real_op; c.exp = e;
        return c;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    // Expand one instruction into its expected trace, then drive and compare it.
    task automatic run_instr(input string name, input logic [5:0] iop, input logic [5:0] ifn,
                             input logic z, input int fw, input int mw);
        cyc_t q[$];
        logic fn_ok;
        logic [2:0] ra;
        logic retire;
        fn_ok  = ifn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ra     = alu_of(ifn);
        retire = 1'b1;
        for (int i = 0; i < fw; i++) q.push_back(mk(1'b0, rbit(), 1'b0, vec(3'd0, 5'b00100, 3'b000, 2'b00, 3'b000)));
        q.push_back(mk(1'b1, rbit(), 1'b0, vec(3'd0, 5'b11100, 3'b000, 2'b00, 3'b000)));
        q.push_back(mk(rbit(), rbit(), 1'b1, vec(3'd1, 5'b00000, 3'b000, 2'b00, 3'b000)));
        if (iop == OP_HALT || !(iop inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J}) ||
            (iop == OP_R && !fn_ok)) begin
            retire   = 1'b0;
            m_halted = 1'b1;
            if (iop != OP_HALT) m_illegal = 1'b1;
            q.push_back(mk(rbit(), rbit(), 1'b0, vec(3'd5, 5'b00000, 3'b000, 2'b00, 3'b000)));
        end else begin
            case (iop)
                OP_R: begin
                    q.push_back(mk(rbit(), rbit(), 1'b0, vec(3'd2, 5'b00000, 3'b000, 2'b00, ra)));
                    q.push_back(mk(rbit(), rbit(), 1'b0, vec(3'd4, 5'b00001, 3'b100, 2'b00, ra)));
                end
                OP_ADDI: begin
                    q.push_back(mk(rbit(), rbit(), 1'b0, vec(3'd2, 5'b00000, 3'b010, 2'b00, 3'b010)));
                    q.push_back(mk(rbit(), rbit(), 1'b0, vec(3'd4, 5'b00001, 3'b010, 2'b00, 3'b010)));
                end
                OP_LW: begin
                    q.push_back(mk(rbit(), rbit(), 1'b0, vec(3'd2, 5'b00000, 3'b010, 2'b00, 3'b010)));
                    for (int i = 0; i < mw; i++) q.push_back(mk(1'b0, rbit(), 1'b0, vec(3'd3, 5'b00100, 3'b010, 2'b00, 3'b010)));
                    q.push_back(mk(1'b1, rbit(), 1'b0, vec(3'd3, 5'b00100, 3'b010, 2'b00, 3'b010)));
                    q.push_back(mk(rbit(), rbit(), 1'b0, vec(3'd4, 5'b00001, 3'b001, 2'b00, 3'b000)));
                end
                OP_SW: begin
                    q.push_back(mk(rbit(), rbit(), 1'b0, vec(3'd2, 5'b00000, 3'b010, 2'b00, 3'b010)));
                    for (int i = 0; i < mw; i++) q.push_back(mk(1'b0, rbit(), 1'b0, vec(3'd3, 5'b00000, 3'b010, 2'b00, 3'b010)));
                    q.push_back(mk(1'b1, rbit(), 1'b0, vec(3'd3, 5'b00010, 3'b010, 2'b00, 3'b010)));
                end
                OP_BEQ: q.push_back(mk(rbit(), z, 1'b0, vec(3'd2, {z, 4'b0000}, 3'b000, 2'b01, 3'b110)));
                default: q.push_back(mk(rbit(), rbit(), 1'b0, vec(3'd2, 5'b10000, 3'b000, 2'b10, 3'b000)));
            endcase
        end
        foreach (q[i]) begin
            @(negedge clk);
            rdy  = q[i].rdy;
            zero = q[i].zero;
            if (q[i].real_op) begin
                op = iop;
                fn = ifn;
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs, q[i].exp);
            end
        end
        if (retire) m_count = m_count + 16'd1;
    endtask

    // Two reset cycles with memory ready high; strobes must stay low throughout.
    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b1;
        zero = 1'b1;
        op = 6'($urandom);
        fn = 6'($urandom);
        #1;
        checks++;
        if ({pc_write, ir_write, mem_read, memdados, bancoreg} !== 5'b00000) begin
            errors++;
            $display("FAIL %s strobes_in_reset: got %b expected 00000", name,
                     {pc_write, ir_write, mem_read, memdados, bancoreg});
        end
        m_count   = 16'd0;
        m_halted  = 1'b0;
        m_illegal = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== vec(3'd0, 5'b00000, 3'b000, 2'b00, 3'b000)) begin
            errors++;
            $display("FAIL %s reset_state: got %h expected %h", name, obs,
                     vec(3'd0, 5'b00000, 3'b000, 2'b00, 3'b000));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset("reset");
        run_instr("rtype_add", OP_R, 6'b100000, 1'b0, 0, 0);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait3", OP_LW, 6'($urandom), 1'b0, 0, 3);
    endtask

    task automatic test_sw_beq();
        run_instr("sw", OP_SW, 6'($urandom), 1'b0, 0, 1);
        run_instr("beq_taken", OP_BEQ, 6'($urandom), 1'b1, 0, 0);
        run_instr("beq_not_taken", OP_BEQ, 6'($urandom), 1'b0, 0, 0);
    endtask

    task automatic test_j_halt();
        run_instr("j", OP_J, 6'($urandom), 1'b0, 0, 0);
        run_instr("halt", OP_HALT, 6'($urandom), 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rdy = rbit();
            op  = 6'($urandom);
            #1;
            checks++;
            if (obs !== vec(3'd5, 5'b00000, 3'b000, 2'b00, 3'b000)) begin
                errors++;
                $display("FAIL halt_hold cycle %0d: got %h expected %h", i, obs,
                         vec(3'd5, 5'b00000, 3'b000, 2'b00, 3'b000));
            end
        end
        do_reset("reset_from_halt");
        run_instr("after_halt_addi", OP_ADDI, 6'($urandom), 1'b0, 1, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_opcode", 6'b010101, 6'($urandom), 1'b0, 0, 0);
        do_reset("reset_after_illegal");
        run_instr("illegal_funct", OP_R, 6'b000000, 1'b0, 2, 0);
        do_reset("reset_after_illegal_funct");
    endtask

    task automatic test_reset_mid_mem();
        @(negedge clk); rdy = 1'b1;
        @(negedge clk); rdy = 1'b0; op = OP_LW; fn = 6'($urandom);
        @(negedge clk); rdy = 1'b0; op = 6'($urandom);
        @(negedge clk); rdy = 1'b0;
        #1;
        checks++;
        if (state !== 3'd3 || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_wait: got state %0d mem_read %b expected state 3 mem_read 1", state, mem_read);
        end
        do_reset("reset_mid_mem");
        run_instr("after_mid_reset_or", OP_R, 6'b100101, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] rfn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] rop [6] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
        for (int n = 0; n < 40; n++) begin
            logic [5:0] o;
            logic [5:0] f;
            o = rop[$urandom_range(0, 5)];
            f = (o == OP_R) ? rfn[$urandom_range(0, 4)] : 6'($urandom);
            run_instr("random", o, f, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_counter_wrap();
        do_reset("reset_before_wrap");
        for (int i = 0; i < 65535 * 3; i++) begin
            @(negedge clk);
            rdy = 1'b1;
            op  = OP_J;
            fn  = 6'($urandom);
        end
        m_count = 16'hFFFF;
        run_instr("wrap_j", OP_J, 6'($urandom), 1'b0, 0, 0);
        run_instr("after_wrap_slt", OP_R, 6'b101010, 1'b0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; zero = 1'b0; op = '0; fn = '0;
        m_count = '0; m_halted = 1'b0; m_illegal = 1'b0;
        test_reset();
        test_lw_wait();
        test_sw_beq();
        test_j_halt();
        test_illegal();
        test_reset_mid_mem();
        test_random();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
